led_cube_scan_sequencer: RTL and testbench
==========================================

// Module: led_cube_scan_sequencer
// PURPOSE
// - Drives the 8x8x8 cube scan from a double-buffered 64-byte frame store; sits between the UART/host byte path and the GPIO pins.
// - Per layer: blank all layers, load 8 row bytes into the eight '574 latches via Data_out/Latches_out, then enable one layer for a dwell time.
// - Host fills the back bank and requests a swap; the swap takes effect only at a frame boundary, so no tearing.
// PARAMETERS
// - DWELL_CYCLES  6250  cycles a layer is lit (50 MHz / 8 layers / 1 kHz)
// - BLANK_CYCLES  4     all-layers-off time before latch loading (anti-ghosting)
// - SETUP_CYCLES  2     Data_out stable before latch pulse rises
// - PULSE_CYCLES  2     latch pulse width (one-hot Latches_out high)
// PORTS
// - clk          in   1  system clock
// - rst_n        in   1  reset, synchronous, active-low
// - enable       in   1  run scan; low = stop at next layer boundary
// - wr_en        in   1  write one byte into back bank
// - wr_addr      in   6  {layer[2:0], row[2:0]}
// - wr_data      in   8  row bitmap, bit n = column n
// - swap_req     in   1  single-cycle request to swap banks at next frame boundary
// - swap_ack     out  1  1-cycle pulse when swap performed
// - frame_done   out  1  1-cycle pulse when layer 7 dwell ends
// - cur_layer    out  3  layer currently loading/lit
// - Layers_out   out  8  one-hot active-high layer enable
// - Latches_out  out  8  one-hot active-high latch clock
// - Data_out     out  8  shared latch data bus
// BEHAVIOUR
// - Reset: all outputs 0, disp_bank=0, swap_pending=0, valid=0, state IDLE, layer=0. Bank RAM not cleared.
// - Back bank = ~disp_bank. wr_en writes back bank same edge; wr_en coincident with swap writes the pre-swap back bank.
// - swap_req sets swap_pending (sticky; repeats while pending are absorbed). Swap executes at frame boundary, or immediately from IDLE.
//   On swap: disp_bank toggles, swap_pending clears, valid=1, swap_ack pulses next cycle.
// - FSM: IDLE -> BLANK -> SETUP -> PULSE -> HOLD -> (row<7: SETUP, row+1) -> ON -> BLANK (layer+1).
//   IDLE: leave when enable && valid (swap from IDLE handled first). All outputs 0.
//   BLANK: Layers_out=0, Latches_out=0, BLANK_CYCLES cycles, row=0.
//   SETUP: Data_out = disp[{layer,row}], SETUP_CYCLES cycles. PULSE: Latches_out=1<<row, PULSE_CYCLES cycles.
//   HOLD: Latches_out=0, Data_out held, 1 cycle. ON: Layers_out=1<<layer, Latches_out=0, DWELL_CYCLES cycles.
// - Layer period = BLANK + 8*(SETUP+PULSE+1) + DWELL cycles (defaults 6294).
// - End of ON with layer==7: frame_done pulses, layer wraps to 0, pending swap executes.
// - End of ON with enable=0: go IDLE (outputs 0, layer reset to 0); enable low mid-layer never truncates a layer.
// - Layers_out and Latches_out never both nonzero; at most one bit set in each.
// - rst_n low at any point: next edge returns to reset values regardless of state.
// - Counters sized $clog2(max param)+1; all params >=1.
// CONFIGURATION
// - LED_CUBE_BRIGHTNESS_EN defined: adds input brightness[3:0]; in ON, Layers_out driven only while dwell_cnt*16 < DWELL_CYCLES*(brightness+1),
//   else 0; ON still lasts full DWELL_CYCLES (constant frame rate). brightness sampled on entry to ON.
// - Not defined: no brightness port; layer lit for entire ON state.
// TESTING (sim params DWELL=16, BLANK=4, SETUP=2, PULSE=2)
// - Write bank1 addr k = k+1 (k=0..63), swap_req, enable=1 -> swap_ack 1 cycle, layer0 latches see bytes 1..8, Layers_out=8'h01 for 16 cycles.
// - Run full frame -> frame_done exactly once per 8*(4+40+16)=480 cycles, cur_layer sequence 0..7 then 0.
// - swap_req mid-layer3 -> no swap until layer7 ON ends; swap_ack coincides with frame boundary; new data appears on layer0.
// - wr_en to back bank during scan -> displayed bytes unchanged; enable=0 during layer2 ON -> layer2 completes, then all outputs 0, IDLE.
// - rst_n low during PULSE -> next cycle Latches_out=0, Layers_out=0, swap_ack=0; no scan until a new swap.
// - LED_CUBE_BRIGHTNESS_EN, brightness=3 -> Layers_out high 4 of 16 ON cycles; brightness=15 -> 16 of 16; assertion: one-hot/exclusive rule always.

Source files
------------

// File: rtl/led_cube_scan_sequencer_if.sv
// Host/pin bundle for the 8x8x8 LED cube scan sequencer.
// Optional LED_CUBE_BRIGHTNESS_EN adds a 4-bit brightness input.
//   master: host side (drives enable, writes, swap_req)
//   slave : sequencer side (drives acks and cube pins)
interface led_cube_scan_sequencer_if;
  logic       enable;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_done;
  logic [2:0] cur_layer;
  logic [7:0] Layers_out;
  logic [7:0] Latches_out;
  logic [7:0] Data_out;
`ifdef LED_CUBE_BRIGHTNESS_EN
  logic [3:0] brightness;
`endif

  modport master (
    output enable,
    output wr_en,
    output wr_addr,
    output wr_data,
    output swap_req,
`ifdef LED_CUBE_BRIGHTNESS_EN
    output brightness,
`endif
    input  swap_ack,
    input  frame_done,
    input  cur_layer,
    input  Layers_out,
    input  Latches_out,
    input  Data_out
  );

  modport slave (
    input  enable,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  swap_req,
`ifdef LED_CUBE_BRIGHTNESS_EN
    input  brightness,
`endif
    output swap_ack,
    output frame_done,
    output cur_layer,
    output Layers_out,
    output Latches_out,
    output Data_out
  );
endinterface

// File: rtl/led_cube_scan_sequencer.sv
// LED cube scan sequencer: double-buffered 64-byte frame store,
// per-layer blank / latch-load / dwell scan of an 8x8x8 cube.
// Ports: clk, rst_n (sync, active-low), bus (slave modport):
//   enable, wr_en, wr_addr[5:0], wr_data[7:0], swap_req in;
//   swap_ack, frame_done, cur_layer[2:0], Layers_out[7:0],
//   Latches_out[7:0], Data_out[7:0] out.
// Optional LED_CUBE_BRIGHTNESS_EN: brightness[3:0] gates Layers_out.
module led_cube_scan_sequencer #(
  parameter int DWELL_CYCLES = 6250,
  parameter int BLANK_CYCLES = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  led_cube_scan_sequencer_if.slave bus
);

  localparam int M1 =
    (DWELL_CYCLES > BLANK_CYCLES) ?
    DWELL_CYCLES : BLANK_CYCLES;
  localparam int M2 =
    (M1 > SETUP_CYCLES) ? M1 : SETUP_CYCLES;
  localparam int MAXP =
    (M2 > PULSE_CYCLES) ? M2 : PULSE_CYCLES;
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] BL_LAST =
    CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SU_LAST =
    CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PU_LAST =
    CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] DW_LAST =
    CW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_ON
  } state_t;

  // Two banks of 64 bytes; index {bank, layer, row}
  logic [7:0] mem [128];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    layer_q, layer_d;
  logic          disp_q, disp_d;
  logic          pend_q, pend_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic          fdone_q, fdone_d;
  logic          do_swap;
  logic [7:0]    rd_byte;
  logic          lit;

  // Writes always target the bank not being shown; a
  // write on the swap edge still lands in the old back bank.
  always_ff @(posedge clk) begin
    if (rst_n && bus.wr_en) begin
      mem[{~disp_q, bus.wr_addr}] <= bus.wr_data;
    end
  end

  assign rd_byte = mem[{disp_q, layer_q, row_q}];

`ifdef LED_CUBE_BRIGHTNESS_EN
  localparam int LW = CW + 5;

  logic [3:0]    bright_q;
  logic [LW-1:0] lit_lhs;
  logic [LW-1:0] lit_rhs;

  // Duty is sampled once per layer so a mid-dwell change
  // never produces a partial step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bright_q <= '0;
    end else if (state_q == S_HOLD &&
                 row_q == 3'd7) begin
      bright_q <= bus.brightness;
    end
  end

  always_comb begin
    lit_lhs = LW'({cnt_q, 4'b0000});
    lit_rhs = LW'(DWELL_CYCLES) *
              LW'({1'b0, bright_q} + 5'd1);
    lit     = (lit_lhs < lit_rhs);
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    row_d   = row_q;
    layer_d = layer_q;
    disp_d  = disp_q;
    pend_d  = pend_q | bus.swap_req;
    valid_d = valid_q;
    ack_d   = 1'b0;
    fdone_d = 1'b0;
    do_swap = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        row_d   = '0;
        layer_d = '0;
        // A pending swap is served before the scan starts
        if (pend_q) begin
          do_swap = 1'b1;
        end else if (bus.enable && valid_q) begin
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        row_d = '0;
        if (cnt_q == BL_LAST) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SU_LAST) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end
      end
      S_PULSE: begin
        if (cnt_q == PU_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (row_q != 3'd7) begin
          state_d = S_SETUP;
          row_d   = row_q + 3'd1;
        end else begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (cnt_q == DW_LAST) begin
          cnt_d = '0;
          if (layer_q == 3'd7) begin
            fdone_d = 1'b1;
            layer_d = '0;
            do_swap = pend_q;
          end else begin
            layer_d = layer_q + 3'd1;
          end
          // enable is only honoured at a layer boundary
          if (!bus.enable) begin
            state_d = S_IDLE;
            layer_d = '0;
          end else begin
            state_d = S_BLANK;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Requests arriving on the swap edge are absorbed
    if (do_swap) begin
      disp_d  = ~disp_q;
      pend_d  = 1'b0;
      valid_d = 1'b1;
      ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      layer_q <= '0;
      disp_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      layer_q <= layer_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      fdone_q <= fdone_d;
    end
  end

  // Pin decode: layer enable and latch clock are
  // confined to disjoint states, so never overlap.
  always_comb begin
    bus.Data_out    = '0;
    bus.Latches_out = '0;
    bus.Layers_out  = '0;
    unique case (state_q)
      S_SETUP, S_HOLD: begin
        bus.Data_out = rd_byte;
      end
      S_PULSE: begin
        bus.Data_out    = rd_byte;
        bus.Latches_out = 8'd1 << row_q;
      end
      S_ON: begin
        if (lit) begin
          bus.Layers_out = 8'd1 << layer_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.swap_ack   = ack_q;
  assign bus.frame_done = fdone_q;
  assign bus.cur_layer  = layer_q;

endmodule

// File: tb/tb_led_cube_scan_sequencer.sv
// Scoreboard bench for led_cube_scan_sequencer.
// Expected events queued by stimulus, popped by a monitor.
module tb_led_cube_scan_sequencer;

  localparam int DW = 16;
  localparam int BL = 4;
  localparam int SU = 2;
  localparam int PU = 2;

  localparam int K_ACK   = 0;
  localparam int K_FRAME = 1;
  localparam int K_LATCH = 2;
  localparam int K_LIT   = 3;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  led_cube_scan_sequencer_if cube ();

  led_cube_scan_sequencer #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .SETUP_CYCLES(SU),
    .PULSE_CYCLES(PU)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (cube.slave)
  );

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [2][64];
  bit mdisp = 1'b0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic void push(input int k,
                               input int a,
                               input int b,
                               input int c);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    e.c = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_layer(input int l,
                                     input int n);
    for (int r = 0; r < 8; r++) begin
      push(K_LATCH, r, int'(mdl[mdisp][l*8+r]), l);
    end
    push(K_LIT, l, n, 0);
  endfunction

  task automatic pop(input int kind,
                     output ev_t e,
                     output bit ok);
    int front;
    front = (exp_q.size() == 0) ? -1 : exp_q[0].kind;
    ok = (front == kind);
    chk("event order", front, kind);
    e.kind = kind;
    e.a = 0;
    e.b = 0;
    e.c = 0;
    if (ok) e = exp_q.pop_front();
  endtask

  logic [7:0] p_lay;
  logic [7:0] p_lat;
  int lit_len = 0;
  int lit_exp = 0;
  int since_fr = 0;

  always @(negedge clk) begin
    ev_t e;
    bit ok;
    bit bad;
    if (!rst_n) begin
      p_lay = '0;
      p_lat = '0;
      lit_len = 0;
      since_fr = 0;
    end else begin
      since_fr++;
      bad = (cube.Layers_out != 0 &&
             cube.Latches_out != 0) ||
            !$onehot0(cube.Layers_out) ||
            !$onehot0(cube.Latches_out);
      chk("layers/latches exclusive", int'(bad), 0);
      if (p_lay != 0 && cube.Layers_out == 0)
        chk("lit cycles", lit_len, lit_exp);
      if (cube.frame_done) begin
        pop(K_FRAME, e, ok);
        if (ok && e.a != 0)
          chk("frame period", since_fr, e.a);
        chk("layer after frame",
            int'(cube.cur_layer), 0);
        since_fr = 0;
      end
      if (cube.swap_ack) pop(K_ACK, e, ok);
      if (cube.Latches_out != 0 && p_lat == 0) begin
        pop(K_LATCH, e, ok);
        if (ok) begin
          chk("latch row", int'(cube.Latches_out),
              1 << e.a);
          chk("latch data", int'(cube.Data_out), e.b);
          chk("latch layer", int'(cube.cur_layer), e.c);
        end
      end
      if (cube.Layers_out != 0 && p_lay == 0) begin
        pop(K_LIT, e, ok);
        if (ok) begin
          chk("lit layer", int'(cube.Layers_out),
              1 << e.a);
          lit_exp = e.b;
        end
        lit_len = 0;
      end
      if (cube.Layers_out != 0) lit_len++;
      p_lay = cube.Layers_out;
      p_lat = cube.Latches_out;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cube.wr_en = 1'b1;
    cube.wr_addr = 6'(a);
    cube.wr_data = 8'(d);
    mdl[!mdisp][a] = 8'(d);
    tick();
    cube.wr_en = 1'b0;
  endtask

  task automatic swap_pulse;
    cube.swap_req = 1'b1;
    tick();
    cube.swap_req = 1'b0;
  endtask

  // Reset asserted just after a negedge so the monitor
  // has already seen the preceding cycle.
  task automatic reset_pulse;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    tick();
  endtask

  task automatic wait_for(input int what,
                          input int arg,
                          input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      tick();
      case (what)
        0: hit = cube.swap_ack;
        1: hit = cube.frame_done;
        2: hit = (int'(cube.cur_layer) == arg);
        3: hit = (int'(cube.Layers_out) == arg);
        default: hit = (cube.Latches_out != 0);
      endcase
    end
    chk({"wait ", nm}, int'(hit), 1);
  endtask

  initial begin
    cube.enable = 1'b0;
    cube.wr_en = 1'b0;
    cube.wr_addr = '0;
    cube.wr_data = '0;
    cube.swap_req = 1'b0;
`ifdef LED_CUBE_BRIGHTNESS_EN
    cube.brightness = 4'd15;
`endif
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst Layers_out", int'(cube.Layers_out), 0);
    chk("rst Latches_out", int'(cube.Latches_out), 0);
    chk("rst Data_out", int'(cube.Data_out), 0);
    chk("rst swap_ack", int'(cube.swap_ack), 0);
    chk("rst frame_done", int'(cube.frame_done), 0);
    chk("rst cur_layer", int'(cube.cur_layer), 0);

    rst_n = 1'b1;
    cube.enable = 1'b1;
    repeat (100) tick();
    chk("idle before swap", int'(cube.Layers_out), 0);
    cube.enable = 1'b0;

    for (int k = 0; k < 64; k++) wr(k, k + 1);
    mdisp = 1'b1;
    push(K_ACK, 0, 0, 0);
    for (int l = 0; l < 8; l++) push_layer(l, DW);
    push(K_FRAME, 0, 0, 0);
    for (int l = 0; l < 8; l++) push_layer(l, DW);
    swap_pulse();
    cube.enable = 1'b1;
    wait_for(0, 0, "first swap_ack");

    for (int k = 0; k < 64; k++) wr(k, k ^ 8'hA5);
    wait_for(1, 0, "frame0 done");
    wait_for(2, 3, "frame1 layer3");
    repeat (10) tick();
    swap_pulse();
    push(K_FRAME, 8 * (BL + 8 * (SU + PU + 1) + DW),
         0, 0);
    push(K_ACK, 0, 0, 0);
    mdisp = 1'b0;
    for (int l = 0; l < 3; l++) push_layer(l, DW);
    wait_for(0, 0, "frame-boundary swap_ack");
    chk("swap_ack on frame boundary",
        int'(cube.frame_done), 1);

    wait_for(3, 8'h04, "layer2 lit");
    cube.enable = 1'b0;
    wait_for(3, 0, "layer2 dark");
    repeat (20) tick();
    chk("idle Layers_out", int'(cube.Layers_out), 0);
    chk("idle Latches_out", int'(cube.Latches_out), 0);
    chk("idle Data_out", int'(cube.Data_out), 0);
    chk("idle cur_layer", int'(cube.cur_layer), 0);
    repeat (100) tick();

    push(K_ACK, 0, 0, 0);
    mdisp = 1'b1;
    push(K_LATCH, 0, int'(mdl[1][0]), 0);
    swap_pulse();
    cube.enable = 1'b1;
    wait_for(4, 0, "latch pulse");
    reset_pulse();
    chk("pulse rst Latches_out",
        int'(cube.Latches_out), 0);
    chk("pulse rst Layers_out",
        int'(cube.Layers_out), 0);
    chk("pulse rst swap_ack", int'(cube.swap_ack), 0);
    rst_n = 1'b1;
    mdisp = 1'b0;
    repeat (150) tick();
    chk("no scan after reset",
        int'(cube.Layers_out), 0);

`ifdef LED_CUBE_BRIGHTNESS_EN
    cube.brightness = 4'd3;
    push(K_ACK, 0, 0, 0);
    mdisp = 1'b1;
    push_layer(0, 4);
    swap_pulse();
    wait_for(3, 8'h01, "dim layer0 lit");
    wait_for(3, 0, "dim layer0 dark");
    reset_pulse();
    rst_n = 1'b1;
    mdisp = 1'b0;
`endif

    cube.enable = 1'b0;
    repeat (5) tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
